// File: rtl/usb_pkg.sv
// Shared USB controller definitions: bit-stuffer run length and FSM state encoding.
package usb_pkg;

  localparam int unsigned BS_MAX_ONES = 6;

  typedef enum logic [1:0] {
    BS_IDLE,
    BS_SEND,
    BS_STUFF
  } bs_state_t;

endpackage

// File: rtl/usb_bit_stuffer_fsm.sv
// Bit-stuffer control: tracks the run of consecutive 1s and schedules one stuffed 0
// after every MAX_ONES of them. Outputs are combinational from state and inputs.
module usb_bit_stuffer_fsm
  import usb_pkg::*;
#(
  parameter int unsigned MAX_ONES = BS_MAX_ONES
) (
  input  logic clock,
  input  logic reset,
  input  logic in_bit,
  input  logic in_sending,
  output logic bs_sending,
  output logic pause,
  output logic pass_bit
);

  localparam int unsigned CW = $clog2(MAX_ONES + 1);

  bs_state_t       state;
  bs_state_t       state_next;
  logic [CW-1:0]   ones_cnt;
  logic [CW-1:0]   cnt_next;
  logic [CW-1:0]   cnt_inc;

  // Counter never exceeds MAX_ONES-1 when registered, so the increment cannot overflow CW.
  assign cnt_inc = ones_cnt + CW'(1);

  // State and run counter; reset drops any pending stuff bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= BS_IDLE;
      ones_cnt <= '0;
    end else begin
      state    <= state_next;
      ones_cnt <= cnt_next;
    end
  end

  // Next state, counter update and output decode.
  always_comb begin
    state_next = state;
    cnt_next   = ones_cnt;
    bs_sending = 1'b0;
    pause      = 1'b0;
    pass_bit   = 1'b0;

    case (state)
      // IDLE holds a cleared counter, so it shares the pass-through path with SEND.
      BS_IDLE, BS_SEND: begin
        if (in_sending) begin
          bs_sending = 1'b1;
          pass_bit   = 1'b1;
          if (!in_bit) begin
            cnt_next   = '0;
            state_next = BS_SEND;
          end else if (cnt_inc == CW'(MAX_ONES)) begin
            cnt_next   = '0;
            state_next = BS_STUFF;
          end else begin
            cnt_next   = cnt_inc;
            state_next = BS_SEND;
          end
        end else begin
          cnt_next   = '0;
          state_next = BS_IDLE;
        end
      end

      // Stuffed 0 is emitted even if the packet just ended.
      BS_STUFF: begin
        bs_sending = 1'b1;
        pause      = 1'b1;
        cnt_next   = '0;
        state_next = in_sending ? BS_SEND : BS_IDLE;
      end

      default: begin
        cnt_next   = '0;
        state_next = BS_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/usb_bit_stuffer.sv
// Transmit-path bit stuffer: zero-latency pass-through with a 0 inserted after
// every MAX_ONES consecutive 1s; feeds the NRZI encoder.
module usb_bit_stuffer
  import usb_pkg::*;
#(
  parameter int unsigned MAX_ONES = BS_MAX_ONES
) (
  input  logic clock,
  input  logic reset,
  input  logic in_bit,
  input  logic in_sending,
  output logic out_bit,
  output logic bs_sending,
  output logic pause
);

  logic pass_bit;

  usb_bit_stuffer_fsm #(
    .MAX_ONES (MAX_ONES)
  ) u_fsm (
    .clock      (clock),
    .reset      (reset),
    .in_bit     (in_bit),
    .in_sending (in_sending),
    .bs_sending (bs_sending),
    .pause      (pause),
    .pass_bit   (pass_bit)
  );

  // Output mux: upstream bit while passing through, constant 0 otherwise.
  assign out_bit = pass_bit ? in_bit : 1'b0;

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// Self-checking bench for usb_bit_stuffer: directed packets plus random packets
// compared cycle by cycle against a stream-level stuffing model.
module tb_usb_bit_stuffer;
  import usb_pkg::*;

  localparam int unsigned MAX_ONES = BS_MAX_ONES;

  logic clock = 1'b0;
  logic reset;
  logic in_bit;
  logic in_sending;
  logic out_bit;
  logic bs_sending;
  logic pause;

  int n_checks = 0;
  int n_errors = 0;

  logic pq[$];

  usb_bit_stuffer #(
    .MAX_ONES (MAX_ONES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_bit     (in_bit),
    .in_sending (in_sending),
    .out_bit    (out_bit),
    .bs_sending (bs_sending),
    .pause      (pause)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Append the low n bits of v, most significant first (first bit sent first).
  task automatic add_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) pq.push_back(v[i]);
  endtask

  // Expected output stream {is_stuff, bit}: a 0 follows every MAX_ONES consecutive 1s.
  function automatic void build_expected(input logic pkt[$], output logic [1:0] eq[$]);
    int run;
    run = 0;
    eq.delete();
    foreach (pkt[i]) begin
      eq.push_back({1'b0, pkt[i]});
      run = pkt[i] ? run + 1 : 0;
      if (run == int'(MAX_ONES)) begin
        eq.push_back(2'b10);
        run = 0;
      end
    end
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_bs"},    32'(bs_sending), 32'd0);
    check_eq({tag, "_out"},   32'(out_bit),    32'd0);
    check_eq({tag, "_pause"}, 32'(pause),      32'd0);
  endtask

  // Drive one packet obeying pause, check every emitted cycle, then idle gap cycles.
  // Entered and left at posedge+1.
  task automatic send_packet(input logic pkt[$], input int gap);
    logic [1:0] eq[$];
    logic [1:0] e;
    int idx;
    int cyc;
    int budget;
    build_expected(pkt, eq);
    idx    = 0;
    cyc    = 0;
    budget = 2 * pkt.size() + 4;
    while ((idx < pkt.size() || eq.size() > 0) && cyc < budget) begin
      if (idx < pkt.size()) begin
        in_sending = 1'b1;
        in_bit     = pkt[idx];
      end else begin
        in_sending = 1'b0;
        in_bit     = 1'($urandom_range(0, 1));
      end
      #1;
      if (eq.size() > 0) begin
        e = eq.pop_front();
        check_eq("pkt_bs",    32'(bs_sending), 32'd1);
        check_eq("pkt_out",   32'(out_bit),    32'(e[0]));
        check_eq("pkt_pause", 32'(pause),      32'(e[1]));
      end else begin
        check_eq("pkt_bs_extra", 32'(bs_sending), 32'd0);
      end
      if (!pause && idx < pkt.size()) idx++;
      cyc++;
      @(posedge clock);
      #1;
    end
    check_eq("pkt_drain", 32'(eq.size() + ((idx < pkt.size()) ? 1 : 0)), 32'd0);
    for (int g = 0; g < gap; g++) begin
      in_sending = 1'b0;
      in_bit     = 1'($urandom_range(0, 1));
      #1;
      check_idle("gap");
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset      = 1'b1;
    in_sending = 1'b0;
    in_bit     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_idle("rst");
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_idle("post_rst");

    // 0000_0001: passes unchanged
    add_bits(32'h01, 8);
    send_packet(pq, 2); pq.delete();

    // eight 1s: one stuff after the sixth
    add_bits(32'hFF, 8);
    send_packet(pq, 2); pq.delete();

    // twelve 1s: second stuff emitted after in_sending drops
    add_bits(32'hFFF, 12);
    send_packet(pq, 2); pq.delete();

    // 1111_1011_1111_1: only the second run stuffs
    add_bits(32'h1F7F, 13);
    send_packet(pq, 2); pq.delete();

    // 111, one idle cycle, then 111000: run does not carry across packets
    add_bits(32'h7, 3);
    send_packet(pq, 1); pq.delete();
    add_bits(32'h38, 6);
    send_packet(pq, 2); pq.delete();

    // reset while in STUFF
    for (int i = 0; i < 6; i++) begin
      in_sending = 1'b1;
      in_bit     = 1'b1;
      #1;
      check_eq("pre_rst_out", 32'(out_bit), 32'd1);
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    #1;
    check_eq("stuff_before_rst", 32'(pause), 32'd1);
    @(posedge clock);
    #1;
    reset      = 1'b0;
    in_sending = 1'b0;
    #1;
    check_idle("rst_in_stuff");
    @(posedge clock);
    #1;
    add_bits(32'h3F, 6);
    send_packet(pq, 2); pq.delete();

    // reset one bit before a stuff, new packet starting immediately afterwards
    for (int i = 0; i < 5; i++) begin
      in_sending = 1'b1;
      in_bit     = 1'b1;
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    #1;
    check_eq("rst_send_out", 32'(out_bit), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    add_bits(32'h3F, 6);
    send_packet(pq, 2); pq.delete();

    // random packets, biased toward long runs of 1s
    for (int p = 0; p < 40; p++) begin
      int len;
      len = int'($urandom_range(1, 40));
      for (int i = 0; i < len; i++) pq.push_back(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0);
      send_packet(pq, int'($urandom_range(1, 3))); pq.delete();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1);
  end

endmodule
